icache: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache. Sits between the instruction fetcher and the memory controller's instruction port (ins_sgn_in / ins_addr / ins_sgn_out / ins_val).
- Hits return in one cycle.
- A miss holds a level request to the memory controller until its one-cycle done pulse, then fills the line and returns the word.
- A flush discards the pending response but not the fill.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_array.sv | 51 +++++
 rtl/icache.sv | 119 +++++++++++
 tb/tb_icache.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
// icache_pkg : shared constants and FSM encoding for the instruction cache
// Rev 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_INDEX_BITS = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// icache_array : valid/tag/data storage, async-read lookup, sync write port
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_BITS-1:0]   rd_idx,
  input  logic [29-INDEX_BITS:0]  rd_tag,
  output logic                    hit,
  output logic [31:0]             rdata,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_idx,
  input  logic [29-INDEX_BITS:0]  wr_tag,
  input  logic [31:0]             wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]          valid;
  logic [29-INDEX_BITS:0]    tags [LINES];
  logic [31:0]               data [LINES];

  // Only the valid bits need reset; stale tags/data are masked by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign hit   = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rdata = data[rd_idx];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// icache : direct-mapped one-word-per-line instruction cache with miss FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic        inst_valid_d;
  logic [31:0] inst_d;
  logic        mem_req_d;
  logic [31:0] mem_addr_d;
  logic        arr_we;
  logic        hit;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr[1:0];

  // The miss address register doubles as the latched fill index/tag.
  icache_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (fetch_addr[INDEX_BITS+1:2]),
    .rd_tag  (fetch_addr[31:INDEX_BITS+2]),
    .hit     (hit),
    .rdata   (rdata),
    .wr_en   (arr_we && rdy),
    .wr_idx  (mem_addr[INDEX_BITS+1:2]),
    .wr_tag  (mem_addr[31:INDEX_BITS+2]),
    .wr_data (mem_data)
  );

  assign fetch_ready = (state_q == ST_IDLE) && rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      discard_q  <= FALSE;
      inst_valid <= FALSE;
      inst       <= '0;
      mem_req    <= FALSE;
      mem_addr   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      inst_valid <= inst_valid_d;
      inst       <= inst_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_req && !flush && !hit) state_d = ST_MISS;
      ST_MISS: if (mem_done) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_valid_d = FALSE;
    inst_d       = inst;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    discard_d    = discard_q;
    arr_we       = FALSE;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !flush) begin
          if (hit) begin
            inst_valid_d = TRUE;
            inst_d       = rdata;
          end else begin
            mem_req_d  = TRUE;
            mem_addr_d = {fetch_addr[31:2], 2'b00};
          end
        end
      end
      ST_MISS: begin
        // The controller cannot abort a word, so a flush only suppresses the response.
        if (flush) discard_d = TRUE;
        if (mem_done) begin
          arr_we       = TRUE;
          mem_req_d    = FALSE;
          inst_valid_d = !(discard_q || flush);
          inst_d       = mem_data;
          discard_d    = FALSE;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// tb_icache : vector table, corner sequences and randomized model check
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;

  icache #(.INDEX_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_mem = 1'b0;
  int mem_cnt = 0;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        done;
    logic [31:0] data;
    logic        e_iv;
    logic [31:0] e_inst;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D0 = 32'h0050_0093;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [31:0] D2 = 32'hCAFE_BABE;
  localparam logic [31:0] D3 = 32'h0000_0013;

  function automatic vec_t mk(logic r, logic q, logic [31:0] a, logic f, logic d,
                              logic [31:0] dat, logic eiv, logic [31:0] ein,
                              logic ereq, logic [31:0] ead, logic erdy);
    vec_t v;
    v.rdy = r; v.req = q; v.addr = a; v.flush = f; v.done = d; v.data = dat;
    v.e_iv = eiv; v.e_inst = ein; v.e_req = ereq; v.e_addr = ead; v.e_ready = erdy;
    return v;
  endfunction

  function automatic logic [31:0] backing(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock; in auto mode a memory controller answers 5 counted cycles after the request.
  task automatic tick();
    logic consumed;
    if (auto_mem) begin
      if (!mem_req) begin
        mem_cnt  = 0;
        mem_done = 1'b0;
      end else if (mem_cnt >= 5) begin
        mem_done = 1'b1;
        mem_data = backing(mem_addr);
      end else if (rdy) begin
        mem_cnt++;
      end
    end
    @(posedge clk);
    consumed = mem_done && rdy;
    #1;
    if (auto_mem && consumed) begin
      mem_done = 1'b0;
      mem_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  bit          ref_ok   [256];
  logic [31:0] ref_addr [256];

  initial begin
    // rdy, req, addr, flush, done, data | iv, inst, req, addr, ready
    vecs.push_back(mk(1, 1, 32'h0,   0, 0, 0,  0, 0,  1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, 0,  1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, 0,  1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, D0, 1, D0, 0, 32'h0,   1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, D0, 0, 32'h0,   1));
    vecs.push_back(mk(1, 1, 32'h0,   0, 0, 0,  1, D0, 0, 32'h0,   1));
    vecs.push_back(mk(1, 1, 32'h400, 0, 0, 0,  0, D0, 1, 32'h400, 0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, D1, 1, D1, 0, 32'h400, 1));
    vecs.push_back(mk(1, 1, 32'h0,   0, 0, 0,  0, D1, 1, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, D0, 1, D0, 0, 32'h0,   1));
    vecs.push_back(mk(1, 1, 32'h10,  0, 0, 0,  0, D0, 1, 32'h10,  0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, D0, 1, 32'h10,  0));
    vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0,  0, D0, 1, 32'h10,  0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0,  0, D0, 1, 32'h10,  0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, D2, 0, D2, 0, 32'h10,  1));
    vecs.push_back(mk(1, 1, 32'h10,  0, 0, 0,  1, D2, 0, 32'h10,  1));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0, D2, 0, 32'h10, 1));
    vecs.push_back(mk(1, 1, 32'h10,  0, 0, 0,  1, D2, 0, 32'h10,  1));
    vecs.push_back(mk(1, 1, 32'h20,  1, 0, 0,  0, D2, 0, 32'h10,  1));
    vecs.push_back(mk(1, 1, 32'h20,  0, 0, 0,  0, D2, 1, 32'h20,  0));
    vecs.push_back(mk(1, 1, 32'h40,  0, 0, 0,  0, D2, 1, 32'h20,  0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0,  0, D2, 1, 32'h20,  0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0,  0, D2, 1, 32'h20,  0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0,  0, D2, 1, 32'h20,  0));
    vecs.push_back(mk(1, 0, 32'h0,   1, 1, D3, 0, D3, 0, 32'h20,  1));
    vecs.push_back(mk(1, 1, 32'h20,  0, 0, 0,  1, D3, 0, 32'h20,  1));

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fetch_ready", fetch_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rdy = vecs[i].rdy; fetch_req = vecs[i].req; fetch_addr = vecs[i].addr;
      flush = vecs[i].flush; mem_done = vecs[i].done; mem_data = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].e_iv);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_req);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_fetch_ready", i), fetch_ready, vecs[i].e_ready);
    end
    rdy = 1; fetch_req = 0; flush = 0; mem_done = 0; mem_data = 0;

    // Asynchronous reset in the middle of a miss
    fetch_req = 1; fetch_addr = 32'h400;
    tick();
    fetch_req = 0;
    chk("arst_pre_mem_req", mem_req, 1);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_req = 1; fetch_addr = 32'h20;
    tick();
    fetch_req = 0;
    chk("arst_refetch_miss", mem_req, 1);
    chk("arst_refetch_addr", mem_addr, 32'h20);
    chk("arst_refetch_iv", inst_valid, 0);
    mem_done = 1; mem_data = D3;
    tick();
    mem_done = 0;
    chk("arst_fill_iv", inst_valid, 1);
    chk("arst_fill_inst", inst, D3);

    // Randomized traffic against a line-address model
    do_reset();
    foreach (ref_ok[i]) ref_ok[i] = 1'b0;
    auto_mem = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      int          idx;
      bit          idle_flush, miss_flush, flushed, done;
      int          flush_at;
      idx        = $urandom_range(0, 15);
      a          = ($urandom_range(0, 3) << 10) | (idx << 2);
      idle_flush = ($urandom_range(0, 7) == 0);
      miss_flush = ($urandom_range(0, 3) == 0);
      rdy = 1; fetch_req = 1; fetch_addr = a; flush = idle_flush;
      tick();
      fetch_req = 0; flush = 0;
      if (idle_flush) begin
        chk($sformatf("rnd%0d_flush_iv", t), inst_valid, 0);
        chk($sformatf("rnd%0d_flush_req", t), mem_req, 0);
      end else if (ref_ok[idx] && ref_addr[idx] == a) begin
        chk($sformatf("rnd%0d_hit_iv", t), inst_valid, 1);
        chk($sformatf("rnd%0d_hit_inst", t), inst, backing(a));
        chk($sformatf("rnd%0d_hit_req", t), mem_req, 0);
      end else begin
        chk($sformatf("rnd%0d_miss_req", t), mem_req, 1);
        chk($sformatf("rnd%0d_miss_addr", t), mem_addr, a);
        chk($sformatf("rnd%0d_miss_iv", t), inst_valid, 0);
        flushed  = 0;
        done     = 0;
        flush_at = miss_flush ? int'($urandom_range(0, 8)) : -1;
        for (int k = 0; k < 60 && !done; k++) begin
          rdy   = ($urandom_range(0, 3) != 0);
          flush = 0;
          if (k == flush_at) begin
            rdy = 1; flush = 1; flushed = 1;
          end
          tick();
          flush = 0;
          if (!mem_req) done = 1;
          else if (inst_valid) chk($sformatf("rnd%0d_early_iv", t), inst_valid, 0);
        end
        rdy = 1;
        chk($sformatf("rnd%0d_miss_timeout", t), done, 1);
        chk($sformatf("rnd%0d_fill_iv", t), inst_valid, !flushed);
        if (!flushed) chk($sformatf("rnd%0d_fill_inst", t), inst, backing(a));
        ref_ok[idx]   = 1'b1;
        ref_addr[idx] = a;
      end
    end
    auto_mem = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
